// File: rtl/score_display_ctrl.sv
// score_display_ctrl: converts a 10-bit score to three BCD digits by
// double dabble and time-multiplexes them onto a shared 7-segment decoder.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | committed digits on display, waiting for a load strobe
// CONVERT | one shift-add-3 step per cycle, ten steps, then commit digits
module score_display_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  score,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bcd_out,
  output logic [2:0]  digit_sel,
  output logic        blank,
  output logic [11:0] digits
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [9:0]    sr_q;
  logic [11:0]   acc_q;
  logic [3:0]    cnt_q;
  logic          capture;
  logic          shift_en;
  logic          commit;
  logic [9:0]    score_sat;
  logic [11:0]   acc_adj;
  logic [11:0]   acc_next;
  logic [PW-1:0] pre_q;
  logic [2:0]    sel_q;

  // Adds 3 to a BCD nibble that would overflow past 9 when doubled.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Saturation and one double-dabble step on the current accumulator.
  always_comb begin
    score_sat = (score > 10'd999) ? 10'd999 : score;
    acc_adj   = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
    acc_next  = {acc_adj[10:0], sr_q[9]};
  end

  // Next-state and datapath strobes; load is only honoured in IDLE.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        shift_en = 1'b1;
        if (cnt_q == 4'd9) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Conversion datapath; digits only change on the final shift so the
  // display never sees a partial result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sr_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      digits <= '0;
      done   <= 1'b0;
    end else begin
      done <= commit;
      if (capture) begin
        sr_q  <= score_sat;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (shift_en) begin
        sr_q  <= {sr_q[8:0], 1'b0};
        acc_q <= acc_next;
        cnt_q <= cnt_q + 4'd1;
      end
      if (commit) begin
        digits <= acc_next;
      end
    end
  end

  // Free-running scan prescaler and one-hot digit rotation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_q <= '0;
      sel_q <= 3'b001;
    end else if (pre_q == PRE_MAX) begin
      pre_q <= '0;
      sel_q <= {sel_q[1:0], sel_q[2]};
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  assign busy      = (state_q == CONVERT);
  assign digit_sel = sel_q;

  // Digit mux and leading-zero suppression; the ones digit is never blanked.
  always_comb begin
    bcd_out = 4'd0;
    blank   = 1'b0;
    case (sel_q)
      3'b001: begin
        bcd_out = digits[3:0];
      end
      3'b010: begin
        bcd_out = digits[7:4];
        blank   = (digits[11:8] == 4'd0) && (digits[7:4] == 4'd0);
      end
      3'b100: begin
        bcd_out = digits[11:8];
        blank   = (digits[11:8] == 4'd0);
      end
      default: begin
        bcd_out = 4'd0;
        blank   = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit stays selected (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port score  input  10  unsigned binary score to display.
REQ-005 SHALL have port load  input  1  one-cycle strobe requesting conversion of score.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when new digits are committed.
REQ-008 SHALL have port bcd_out  output  4  BCD nibble of the selected digit, fed to the shared 7-segment decoder.
REQ-009 SHALL have port digit_sel  output  3  one-hot digit enable: 001 ones, 010 tens, 100 hundreds.
REQ-010 SHALL have port blank  output  1  high when the selected digit is a suppressed leading zero.
REQ-011 SHALL have port digits  output  12  committed BCD value {hundreds, tens, ones}, for debug and verification.

Function
REQ-012 SHALL implement FSM states IDLE and CONVERT; IDLE->CONVERT on load, CONVERT->IDLE after the 10th shift.
REQ-013 SHALL, on load in IDLE, capture score saturated to 999 (score > 999 -> 999) into the shift register and clear the BCD accumulator.
REQ-014 SHALL ignore load while in CONVERT (no capture, no restart, no queueing).
REQ-015 SHALL convert by shift-add-3 (double dabble), one shift per cycle: before each shift, any BCD nibble >= 5 gets +3.
REQ-016 SHALL assert busy from the cycle after load through the cycle of the 10th shift; busy SHALL be high for exactly 10 cycles.
REQ-017 SHALL write digits atomically on the clock edge ending the 10th shift cycle; done SHALL be high for exactly the following cycle; total latency is load edge to done = 11 cycles.
REQ-018 SHALL leave digits unchanged during CONVERT; the display shows only committed digits, never partial results.
REQ-019 SHALL allow load in the same cycle done is high; the conversion starts normally.
REQ-020 SHALL run a prescaler 0..SCAN_DIV-1 continuously, independent of FSM state; on reaching SCAN_DIV-1 it wraps to 0 and the scan index advances ones->tens->hundreds->ones.
REQ-021 SHALL drive bcd_out combinationally from the committed digit selected by the scan index; digit_sel SHALL always be exactly one-hot.
REQ-022 SHALL assert blank for hundreds when hundreds==0, for tens when hundreds==0 and tens==0, and never for ones; bcd_out still carries the digit value when blanked.
REQ-023 SHALL have all arithmetic in fixed widths: 10-bit shift register, 12-bit BCD accumulator, 4-bit shift counter, prescaler ceil(log2(SCAN_DIV)) bits; no overflow is possible for inputs <= 999.

Reset
REQ-024 SHALL, when resetn is low at a clock edge, set FSM=IDLE, busy=0, done=0, digits=12'h000, shift counter=0, prescaler=0, scan index=ones (digit_sel=001); therefore bcd_out=0 and blank=0.
REQ-025 SHALL, on reset during CONVERT, abort the conversion with no done pulse, leaving digits=000.
REQ-026 SHALL take resetn priority over load in the same cycle.

Verification
REQ-027 SHALL be checked by directed test: reset, load with score=10'd237 -> busy high 10 cycles, done at cycle 11, digits=12'h237, no blanking.
REQ-028 SHALL be checked by directed test: load score=10'd1023 -> digits=12'h999; then load score=0 -> digits=12'h000, blank high on hundreds and tens, low on ones.
REQ-029 SHALL be checked by directed test: load 5, then pulse load with score=888 on cycles 3 and 7 of CONVERT -> single done, digits=12'h005; on the done cycle load 42 -> digits=12'h042 eleven cycles later.
REQ-030 SHALL be checked by directed test: SCAN_DIV=4, digits=12'h907 -> digit_sel 001,010,100,001 each held 4 cycles; bcd_out 7,0,9; blank never high.
REQ-031 SHALL be checked by directed test: assert resetn low at cycle 5 of a conversion of 999 -> no done, digits=12'h000, digit_sel=001, prescaler restarted from 0.
REQ-032 SHALL be checked by exhaustive sweep: scores 0..1023 -> digits equals decimal of min(score,999) for every value.
